dma_reset_ctrl: RTL and testbench
=================================

Name: dma_reset_ctrl

Overview:
Reset sequencer that consumes the raw testbench/board clock and reset and produces the staged, synchronised resets for the AXI DMA datapath. It performs power-on sequencing and DMACR.Reset-style soft resets. Channels are drained of outstanding AXI transactions before reset, with a timeout fallback. It sits directly downstream of the clock/reset generator and upstream of the MM2S/S2MM channel logic.

Parameters:
SYNC_STAGES, 2, flops in the reset-deassertion synchroniser (>=2)
HOLD_CYCLES, 16, cycles all resets are held after synchronised release or soft-reset entry (>=1)
STAGGER, 4, cycles between successive channel reset releases (>=1)
DRAIN_TIMEOUT, 1024, max cycles spent waiting for channels to go idle (>=1)

Ports:
axi_aclk  input  1  system clock
axi_reset  input  1  asynchronous, active-high reset
soft_rst_req  input  1  single-cycle soft-reset request (DMACR.Reset write)
mm2s_busy  input  1  MM2S channel has outstanding AXI transactions
s2mm_busy  input  1  S2MM channel has outstanding AXI transactions
core_rst  output  1  active-high reset to register file/common logic
mm2s_rst  output  1  active-high reset to MM2S channel
s2mm_rst  output  1  active-high reset to S2MM channel
halt_req  output  1  instructs channels to stop issuing new transactions
soft_rst_pending  output  1  DMACR.Reset readback
rst_done  output  1  one-cycle pulse when the sequence completes
drain_timeout  output  1  sticky: last drain ended by timeout

Behaviour:
- Single clock domain: axi_aclk. Reset axi_reset is asynchronous and active-high.
- Reset values: core_rst=1, mm2s_rst=1, s2mm_rst=1, halt_req=0, soft_rst_pending=0, rst_done=0, drain_timeout=0.
- axi_reset asserts all outputs to reset values immediately and asynchronously, at any state and mid-sequence.
- Deassertion passes through an SYNC_STAGES-flop synchroniser. The FSM leaves reset only on the synchronised signal.
- States: ASSERT, REL_MM2S, REL_S2MM, RUN, DRAIN. The state after reset is ASSERT.
- ASSERT:
  - All three resets are high. hold_cnt counts 0..HOLD_CYCLES-1.
  - At terminal count, core_rst falls on the next edge and the FSM goes to REL_MM2S.
- REL_MM2S: stag_cnt counts 0..STAGGER-1. At terminal count, mm2s_rst falls and the FSM goes to REL_S2MM.
- REL_S2MM: same count. At terminal count, s2mm_rst falls, rst_done pulses for 1 cycle, soft_rst_pending clears and the FSM goes to RUN.
- Power-on timing, counted in rising edges after the first edge sampling axi_reset low:
  - core_rst low at edge SYNC_STAGES+HOLD_CYCLES (18 with defaults).
  - mm2s_rst low at edge +STAGGER (22).
  - s2mm_rst low and rst_done high at edge +2*STAGGER (26).
- RUN:
  - soft_rst_req=1 moves the FSM to DRAIN. soft_rst_pending=1 and halt_req=1 take effect on the next edge.
  - The drain counter clears and drain_timeout clears.
- DRAIN:
  - Each cycle, sample mm2s_busy|s2mm_busy.
  - If both are 0: on the next edge, all three resets go high, halt_req goes low, and the FSM enters ASSERT with hold_cnt=0.
  - Else drain_cnt increments. When drain_cnt==DRAIN_TIMEOUT-1 and the channels are still busy, the FSM forces the same ASSERT entry and sets drain_timeout=1.
  - If both channels are already idle on the first DRAIN cycle, ASSERT is entered after exactly 1 DRAIN cycle.
- Soft-reset sequence is identical to power-on from ASSERT onward.
  - soft_rst_pending stays 1 through ASSERT/REL_* and clears with the rst_done pulse.
  - drain_timeout persists until the next soft_rst_req or axi_reset.
- soft_rst_req outside RUN (DRAIN, ASSERT, REL_*) is ignored, and no request is queued.
- soft_rst_req coincident with synchroniser release is ignored.
- Counters are sized $clog2(max(HOLD_CYCLES,STAGGER,DRAIN_TIMEOUT)+1) bits, unsigned, and never wrap (reset on state entry).
- All outputs are registered (no combinational paths from inputs to outputs).

Decomposition:
- Package dma_rst_pkg:
  - rst_state_e enum (ASSERT, REL_MM2S, REL_S2MM, RUN, DRAIN).
  - Default constants for the four parameters.
  - Counter-width function.
- Sub-module rst_sync: SYNC_STAGES flop chain, async assert / sync deassert, active-high. Instantiated once.

Test Plan:
- Power-on: axi_reset high 10 cycles then low. Required: core_rst low at edge 18, mm2s_rst low at 22, s2mm_rst low at 26, rst_done high only at 26, soft_rst_pending=0 throughout.
- Soft reset, idle channels: in RUN pulse soft_rst_req with busy=0. Required:
  - halt_req/soft_rst_pending high on +1.
  - All resets high on +2.
  - core_rst low on +18, s2mm_rst low and rst_done pulse on +26.
  - soft_rst_pending low on +26.
- Drain wait: soft_rst_req with mm2s_busy=1 for 50 cycles then 0. Required: resets stay low and halt_req high for those 50 cycles, resets assert 1 cycle after busy drops, drain_timeout=0.
- Timeout: DRAIN_TIMEOUT=32, s2mm_busy held 1. Required: resets assert after 32 DRAIN cycles, drain_timeout=1, sequence completes, drain_timeout stays 1 until the next soft_rst_req.
- Reset mid-sequence: assert axi_reset during REL_MM2S and during DRAIN. Required:
  - All outputs return to reset values immediately (same timestep, no clock edge).
  - After release, the full 18/22/26 timeline repeats.
- Ignored requests: pulse soft_rst_req during ASSERT and REL_S2MM. Required: no extra sequence; FSM in RUN after rst_done with soft_rst_pending=0.

Source files
------------

// File: rtl/dma_rst_pkg.sv
// Shared types and defaults for the DMA reset sequencer.
package dma_rst_pkg;

  typedef enum logic [2:0] {
    StAssert,
    StRelMm2s,
    StRelS2mm,
    StRun,
    StDrain
  } rst_state_e;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefHoldCycles  = 16;
  localparam int unsigned DefStagger     = 4;
  localparam int unsigned DefDrainTimeout = 1024;

  // One shared counter serves all states, so size it for the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned stagger,
                                            input int unsigned timeout);
    int unsigned m;
    m = hold;
    if (stagger > m) m = stagger;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Active-high reset synchroniser: asynchronous assert, synchronous deassert.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_in,
  output logic rst_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dma_reset_ctrl.sv
// Staged reset sequencer for the AXI DMA: power-on release, channel drain and soft reset.
module dma_reset_ctrl
  import dma_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
  parameter int unsigned STAGGER       = DefStagger,
  parameter int unsigned DRAIN_TIMEOUT = DefDrainTimeout
) (
  input  logic axi_aclk,
  input  logic axi_reset,
  input  logic soft_rst_req,
  input  logic mm2s_busy,
  input  logic s2mm_busy,
  output logic core_rst,
  output logic mm2s_rst,
  output logic s2mm_rst,
  output logic halt_req,
  output logic soft_rst_pending,
  output logic rst_done,
  output logic drain_timeout
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGGER, DRAIN_TIMEOUT);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast  = CntW'(STAGGER - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_TIMEOUT - 1);

  logic            sync_rst;
  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            core_d, mm2s_d, s2mm_d, halt_d, pending_d, done_d, timeout_d;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk    (axi_aclk),
    .rst_in (axi_reset),
    .rst_out(sync_rst)
  );

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= StAssert;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    done_d    = 1'b0;
    pending_d = soft_rst_pending;
    timeout_d = drain_timeout;
    if (sync_rst) begin
      state_d   = StAssert;
      cnt_d     = '0;
      pending_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_d = StRelMm2s;
            cnt_d   = '0;
          end
        end
        StRelMm2s: begin
          if (cnt_q == StagLast) begin
            state_d = StRelS2mm;
            cnt_d   = '0;
          end
        end
        StRelS2mm: begin
          if (cnt_q == StagLast) begin
            state_d   = StRun;
            cnt_d     = '0;
            done_d    = 1'b1;
            pending_d = 1'b0;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (soft_rst_req) begin
            state_d   = StDrain;
            pending_d = 1'b1;
            timeout_d = 1'b0;
          end
        end
        StDrain: begin
          if (!(mm2s_busy || s2mm_busy)) begin
            state_d = StAssert;
            cnt_d   = '0;
          end else if (cnt_q == DrainLast) begin
            state_d   = StAssert;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
        default: begin
          state_d = StAssert;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    core_d = (state_d == StAssert);
    mm2s_d = core_d || (state_d == StRelMm2s);
    s2mm_d = mm2s_d || (state_d == StRelS2mm);
    halt_d = (state_d == StDrain);
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      core_rst         <= 1'b1;
      mm2s_rst         <= 1'b1;
      s2mm_rst         <= 1'b1;
      halt_req         <= 1'b0;
      soft_rst_pending <= 1'b0;
      rst_done         <= 1'b0;
      drain_timeout    <= 1'b0;
    end else begin
      core_rst         <= core_d;
      mm2s_rst         <= mm2s_d;
      s2mm_rst         <= s2mm_d;
      halt_req         <= halt_d;
      soft_rst_pending <= pending_d;
      rst_done         <= done_d;
      drain_timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_dma_reset_ctrl.sv
// Scoreboard bench for dma_reset_ctrl: default instance plus a short-timeout instance.
module tb_dma_reset_ctrl;

  localparam int H  = 16;
  localparam int S  = 4;
  localparam int SY = 2;
  localparam logic [6:0] RstVec = 7'b111_0000;

  typedef struct {
    int         cyc;
    bit         sel;
    logic [6:0] exp;
    string      tag;
  } sb_t;

  logic clk;
  logic axi_reset;
  logic req1, mbusy1, sbusy1, req2, mbusy2, sbusy2;
  logic core1, mm2s1, s2mm1, halt1, pend1, done1, to1;
  logic core2, mm2s2, s2mm2, halt2, pend2, done2, to2;
  logic [6:0] vec1, vec2;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  sb_t sb[$];

  assign vec1 = {core1, mm2s1, s2mm1, halt1, pend1, done1, to1};
  assign vec2 = {core2, mm2s2, s2mm2, halt2, pend2, done2, to2};

  dma_reset_ctrl u_dut1 (
    .axi_aclk        (clk),
    .axi_reset       (axi_reset),
    .soft_rst_req    (req1),
    .mm2s_busy       (mbusy1),
    .s2mm_busy       (sbusy1),
    .core_rst        (core1),
    .mm2s_rst        (mm2s1),
    .s2mm_rst        (s2mm1),
    .halt_req        (halt1),
    .soft_rst_pending(pend1),
    .rst_done        (done1),
    .drain_timeout   (to1)
  );

  dma_reset_ctrl #(
    .DRAIN_TIMEOUT(32)
  ) u_dut2 (
    .axi_aclk        (clk),
    .axi_reset       (axi_reset),
    .soft_rst_req    (req2),
    .mm2s_busy       (mbusy2),
    .s2mm_busy       (sbusy2),
    .core_rst        (core2),
    .mm2s_rst        (mm2s2),
    .s2mm_rst        (s2mm2),
    .halt_req        (halt2),
    .soft_rst_pending(pend2),
    .rst_done        (done2),
    .drain_timeout   (to2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge 1 is the first rising edge that samples axi_reset low.
  always @(posedge clk or posedge axi_reset) begin
    if (axi_reset) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {core,mm2s,s2mm,halt,pending,done,timeout} k edges after ASSERT entry.
  function automatic logic [6:0] seq_exp(input int k, input bit pend, input bit to);
    logic c, m, s, d, p;
    c = (k < H);
    m = (k < H + S);
    s = (k < H + 2 * S);
    d = (k == H + 2 * S);
    p = pend && (k < H + 2 * S);
    return {c, m, s, 1'b0, p, d, to};
  endfunction

  function automatic logic [6:0] drain_exp(input bit to);
    return {3'b000, 1'b1, 1'b1, 1'b0, to};
  endfunction

  task automatic push(input bit sel, input int c, input logic [6:0] e, input string tag);
    sb_t ent;
    ent.cyc = c;
    ent.sel = sel;
    ent.exp = e;
    ent.tag = tag;
    sb.push_back(ent);
  endtask

  task automatic push_seq(input bit sel, input int a, input int first, input int last,
                          input bit pend, input bit to, input string tag);
    for (int c = first; c <= last; c++) push(sel, c, seq_exp(c - a, pend, to), tag);
  endtask

  task automatic wait_edge(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("reach_edge_%0d", n), cyc, n);
  endtask

  task automatic pulse_req(input bit sel);
    if (sel) req2 = 1'b1;
    else req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    req2 = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check($sformatf("%s_dut%0d@%0d", sb[i].tag, sb[i].sel + 1, cyc),
              {25'd0, (sb[i].sel ? vec2 : vec1)}, {25'd0, sb[i].exp});
        sb.delete(i);
      end
    end
  end

  initial begin
    axi_reset = 1'b1;
    {req1, mbusy1, sbusy1, req2, mbusy2, sbusy2} = '0;
    repeat (10) @(negedge clk);
    check("reset_dut1", {25'd0, vec1}, {25'd0, RstVec});
    check("reset_dut2", {25'd0, vec2}, {25'd0, RstVec});

    // Power-on: 18/22/26 timeline on both instances.
    push_seq(0, SY, 1, 30, 0, 0, "por");
    push_seq(1, SY, 1, 30, 0, 0, "por");
    axi_reset = 1'b0;
    wait_edge(30);

    // Soft reset with idle channels; requests during ASSERT and REL_S2MM are ignored.
    push(0, 31, drain_exp(0), "soft_idle_drain");
    push_seq(0, 32, 32, 60, 1, 0, "soft_idle");
    pulse_req(0);
    wait_edge(40);
    pulse_req(0);
    wait_edge(53);
    pulse_req(0);
    wait_edge(60);

    // Drain wait: mm2s busy for 50 sampled edges.
    for (int c = 61; c <= 110; c++) push(0, c, drain_exp(0), "drain_wait");
    push_seq(0, 111, 111, 139, 1, 0, "drain_seq");
    mbusy1 = 1'b1;
    pulse_req(0);
    wait_edge(110);
    mbusy1 = 1'b0;
    wait_edge(140);

    // Timeout on the 32-cycle instance, then a clean soft reset clears the sticky flag.
    for (int c = 141; c <= 172; c++) push(1, c, drain_exp(0), "to_drain");
    push_seq(1, 173, 173, 205, 1, 1, "to_seq");
    sbusy2 = 1'b1;
    pulse_req(1);
    wait_edge(190);
    sbusy2 = 1'b0;
    wait_edge(205);
    push(1, 206, drain_exp(0), "to_clear_drain");
    push_seq(1, 207, 207, 235, 1, 0, "to_clear");
    pulse_req(1);
    wait_edge(235);

    // axi_reset while dut1 is in REL_MM2S.
    push(0, 236, drain_exp(0), "mid_rel_drain");
    push_seq(0, 237, 237, 255, 1, 0, "mid_rel");
    pulse_req(0);
    wait_edge(255);
    #2 axi_reset = 1'b1;
    #1;
    check("async_rel_dut1", {25'd0, vec1}, {25'd0, RstVec});
    check("async_rel_dut2", {25'd0, vec2}, {25'd0, RstVec});
    @(negedge clk);
    @(negedge clk);
    push_seq(0, SY, 1, 30, 0, 0, "por2");
    push_seq(1, SY, 1, 30, 0, 0, "por2");
    axi_reset = 1'b0;
    wait_edge(30);

    // axi_reset while dut1 is in DRAIN.
    for (int c = 31; c <= 35; c++) push(0, c, drain_exp(0), "mid_drain");
    mbusy1 = 1'b1;
    pulse_req(0);
    wait_edge(35);
    #2 axi_reset = 1'b1;
    #1;
    check("async_drain_dut1", {25'd0, vec1}, {25'd0, RstVec});
    check("async_drain_dut2", {25'd0, vec2}, {25'd0, RstVec});
    mbusy1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_seq(0, SY, 1, 30, 0, 0, "por3");
    push_seq(1, SY, 1, 30, 0, 0, "por3");
    axi_reset = 1'b0;
    wait_edge(30);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
